// File: rtl/cond_branch_handler.sv
// cond_branch_handler: ID-stage ARM condition evaluation and branch resolution.
// Selects forwarded EX flags or committed flags and evaluates the 4-bit
// condition field combinationally. A taken B/BL is sequenced by a small
// IDLE/FLUSH state machine. This produces one-cycle Branch_Taken and Link_En
// pulses and a Flush window that lasts FLUSH_CYCLES cycles.
// Optional feature macro: BRANCH_STATS_EN. It adds the Taken_Count output,
// which is a CNT_W-bit wrapping count of accepted branches.
module cond_branch_handler #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [3:0]       Real_CC,
  input  logic [3:0]       EX_CC,
  input  logic             EX_S,
  input  logic [3:0]       Cond,
  input  logic             B_instr,
  input  logic             L_bit,
  input  logic             Stall,
  output logic             Cond_Pass,
  output logic             Branch_Taken,
  output logic             Link_En,
  output logic             Flush,
  output logic             Busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] Taken_Count
`endif
);

  // Elaboration guard. An illegal configuration produces an empty block.
  // This keeps both parameters referenced in every build.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || CNT_W < 1) begin : g_param_range
  end

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       branch_taken_q, branch_taken_d;
  logic       link_en_q, link_en_d;
  logic       flush_q, flush_d;
  logic [3:0] eff_cc;
  logic       flag_z, flag_c, flag_n, flag_v;
  logic       cond_pass;
  logic       take_branch;

  // Forward EX flags when the EX instruction updates flags at the next edge.
  // This hides the one-cycle write latency of the status register.
  always_comb begin
    eff_cc = EX_S ? EX_CC : Real_CC;
    flag_z = eff_cc[3];
    flag_c = eff_cc[2];
    flag_n = eff_cc[1];
    flag_v = eff_cc[0];
  end

  // ARM condition-field evaluation. It is independent of state, Stall and CLR.
  always_comb begin
    cond_pass = 1'b0;
    unique case (Cond)
      4'b0000: cond_pass = flag_z;                               // EQ
      4'b0001: cond_pass = !flag_z;                              // NE
      4'b0010: cond_pass = flag_c;                               // CS
      4'b0011: cond_pass = !flag_c;                              // CC
      4'b0100: cond_pass = flag_n;                               // MI
      4'b0101: cond_pass = !flag_n;                              // PL
      4'b0110: cond_pass = flag_v;                               // VS
      4'b0111: cond_pass = !flag_v;                              // VC
      4'b1000: cond_pass = flag_c && !flag_z;                    // HI
      4'b1001: cond_pass = !flag_c || flag_z;                    // LS
      4'b1010: cond_pass = (flag_n == flag_v);                   // GE
      4'b1011: cond_pass = (flag_n != flag_v);                   // LT
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);        // GT
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);         // LE
      4'b1110: cond_pass = 1'b1;                                 // AL
      default: cond_pass = 1'b0;                                 // NV
    endcase
  end

  assign Cond_Pass = cond_pass;

  // A branch is accepted only from IDLE when ID is not stalled.
  // Branches that arrive during FLUSH are squashed and ignored.
  assign take_branch = (state_q == ST_IDLE) && !Stall && B_instr && cond_pass;

  // Next-state and registered-output logic. Stall holds the state and flush
  // window, while the pulse outputs always fall so that they never stretch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_d        = flush_q;
    branch_taken_d = 1'b0;
    link_en_d      = 1'b0;
    if (!Stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (take_branch) begin
            state_d        = ST_FLUSH;
            cnt_d          = CNT_INIT;
            branch_taken_d = 1'b1;
            link_en_d      = L_bit;
            flush_d        = 1'b1;
          end else begin
            flush_d = 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_d = ST_IDLE;
            flush_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - 3'd1;
            flush_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  // State register. Synchronous clear overrides everything, even mid-flush.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      branch_taken_q <= 1'b0;
      link_en_q      <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      branch_taken_q <= branch_taken_d;
      link_en_q      <= link_en_d;
      flush_q        <= flush_d;
    end
  end

  assign Branch_Taken = branch_taken_q;
  assign Link_En      = link_en_q;
  assign Flush        = flush_q;
  assign Busy         = (state_q == ST_FLUSH);

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // The count advances only on an accepted IDLE->FLUSH transition. The
  // take_branch term is already false under Stall, so the count holds then.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (take_branch) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  // Taken-branch counter register. It wraps naturally at all-ones.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign Taken_Count = taken_cnt_q;
`endif

endmodule
